// File: rtl/config_host_ctrl.sv
// Host-side initiator for the chip configuration protocol: turns write/read commands into
// parity-protected 64-bit config packets, matches read replies and forwards all other traffic.
module config_host_ctrl #(
  parameter int          WIDTH          = 64,
  parameter logic [31:0] MAGIC_NUMBER   = 32'h8950_4E47,
  parameter int          TIMEOUT_CYCLES = 65535,
  parameter int          TO_BITS        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [7:0]       cmd_chip_id,
  input  logic [7:0]       cmd_addr,
  input  logic [7:0]       cmd_wdata,
  output logic [WIDTH-1:0] tx_packet,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [WIDTH-1:0] rx_packet,
  input  logic             rx_valid,
  output logic             rsp_valid,
  output logic [7:0]       rsp_rdata,
  output logic [1:0]       rsp_error,
  output logic             data_valid,
  output logic [WIDTH-1:0] data_packet
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_RSP, S_DONE} state_e;

  localparam logic [1:0]         TYPE_WR = 2'b10;
  localparam logic [1:0]         TYPE_RD = 2'b11;
  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic               wr_q, wr_d;
  logic [7:0]         chip_q, chip_d;
  logic [7:0]         addr_q, addr_d;
  logic [WIDTH-1:0]   tx_packet_q, tx_packet_d;
  logic [TO_BITS-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]         rsp_rdata_q, rsp_rdata_d;
  logic [1:0]         rsp_error_q, rsp_error_d;
  logic               data_valid_q, data_valid_d;
  logic [WIDTH-1:0]   data_packet_q, data_packet_d;

  logic [TO_BITS-1:0] to_cnt_inc;
  logic               rx_match;
  logic               rx_parity_ok;

  function automatic logic [WIDTH-1:0] build_pkt(input logic       wr,
                                                 input logic [7:0] chip,
                                                 input logic [7:0] addr,
                                                 input logic [7:0] data);
    logic [62:0] body;
    body = {5'b0, MAGIC_NUMBER, data, addr, chip, (wr ? TYPE_WR : TYPE_RD)};
    return {~^body, body};
  endfunction

  assign to_cnt_inc   = to_cnt_q + TO_BITS'(1);
  assign rx_parity_ok = ^rx_packet;
  // Only a reply to the outstanding read is consumed; everything else goes to the data stream.
  assign rx_match = (state_q == S_WAIT_RSP) && rx_valid &&
                    (rx_packet[1:0] == TYPE_RD) && (rx_packet[9:2] == chip_q) &&
                    (rx_packet[17:10] == addr_q) && (rx_packet[57:26] == MAGIC_NUMBER);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    wr_d          = wr_q;
    chip_d        = chip_q;
    addr_d        = addr_q;
    tx_packet_d   = tx_packet_q;
    to_cnt_d      = to_cnt_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_error_d   = rsp_error_q;
    data_valid_d  = rx_valid && !rx_match;
    data_packet_d = (rx_valid && !rx_match) ? rx_packet : data_packet_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          wr_d        = cmd_write;
          chip_d      = cmd_chip_id;
          addr_d      = cmd_addr;
          tx_packet_d = build_pkt(cmd_write, cmd_chip_id, cmd_addr,
                                  cmd_write ? cmd_wdata : 8'h00);
          rsp_rdata_d = 8'h00;
          rsp_error_d = 2'b00;
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          to_cnt_d = '0;
          state_d  = wr_q ? S_DONE : S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        to_cnt_d = to_cnt_inc;
        // A reply landing on the final wait cycle still beats the timeout.
        if (rx_match) begin
          rsp_rdata_d = rx_parity_ok ? rx_packet[25:18] : 8'h00;
          rsp_error_d = {~rx_parity_ok, 1'b0};
          state_d     = S_DONE;
        end else if (to_cnt_inc == TO_LAST) begin
          rsp_rdata_d = 8'h00;
          rsp_error_d = 2'b01;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      wr_q          <= 1'b0;
      chip_q        <= 8'h00;
      addr_q        <= 8'h00;
      tx_packet_q   <= '0;
      to_cnt_q      <= '0;
      rsp_rdata_q   <= 8'h00;
      rsp_error_q   <= 2'b00;
      data_valid_q  <= 1'b0;
      data_packet_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_q          <= wr_d;
      chip_q        <= chip_d;
      addr_q        <= addr_d;
      tx_packet_q   <= tx_packet_d;
      to_cnt_q      <= to_cnt_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      data_valid_q  <= data_valid_d;
      data_packet_q <= data_packet_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign tx_valid    = (state_q == S_SEND);
  assign rsp_valid   = (state_q == S_DONE);
  assign tx_packet   = tx_packet_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;
  assign data_valid  = data_valid_q;
  assign data_packet = data_packet_q;

endmodule

// File: tb/tb_config_host_ctrl.sv
// Self-checking bench for config_host_ctrl: directed protocol cases followed by randomized
// transactions, checked against a transaction-level model of packets, replies and forwarding.
module tb_config_host_ctrl;

  localparam logic [31:0] MAGIC = 32'h8950_4E47;
  localparam int          TO    = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_write;
  logic [7:0]  cmd_chip_id, cmd_addr, cmd_wdata;
  logic        cmd_ready;
  logic [63:0] tx_packet;
  logic        tx_valid, tx_ready;
  logic [63:0] rx_packet;
  logic        rx_valid;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [1:0]  rsp_error;
  logic        data_valid;
  logic [63:0] data_packet;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] fwd_q[$];

  config_host_ctrl #(.WIDTH(64), .MAGIC_NUMBER(MAGIC), .TIMEOUT_CYCLES(TO), .TO_BITS(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_chip_id(cmd_chip_id), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .tx_packet(tx_packet), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_packet(rx_packet), .rx_valid(rx_valid),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .data_valid(data_valid), .data_packet(data_packet)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packet as the protocol defines it, parity from an explicit count of ones.
  function automatic logic [63:0] make_pkt(input logic [1:0] ty, input logic [7:0] chip,
                                           input logic [7:0] addr, input logic [7:0] data,
                                           input logic [31:0] magic);
    logic [63:0] p;
    int ones;
    p = '0;
    p[1:0]   = ty;
    p[9:2]   = chip;
    p[17:10] = addr;
    p[25:18] = data;
    p[57:26] = magic;
    ones = 0;
    for (int i = 0; i < 63; i++) ones += int'(p[i]);
    p[63] = (ones % 2 == 0);
    return p;
  endfunction

  // Packets the reader must ignore: wrong address, wrong chip, write type, wrong magic.
  function automatic logic [63:0] noise_pkt(input int kind, input logic [7:0] chip,
                                            input logic [7:0] addr, input logic [7:0] data);
    case (kind % 4)
      0:       return make_pkt(2'b11, chip, addr + 8'd1, data, MAGIC);
      1:       return make_pkt(2'b11, chip + 8'd1, addr, data, MAGIC);
      2:       return make_pkt(2'b10, chip, addr, data, MAGIC);
      default: return make_pkt(2'b11, chip, addr, data, MAGIC ^ 32'h1);
    endcase
  endfunction

  // Every data_valid pulse must deliver the next expected forwarded packet, in order.
  always @(posedge clk) begin
    #1;
    if (reset_n && data_valid) begin
      if (fwd_q.size() == 0) check("fwd_spurious", data_valid, 1'b0);
      else check("fwd_packet", data_packet, fwd_q.pop_front());
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"},   cmd_ready,   1'b1);
    check({tag, "_tx_valid"},    tx_valid,    1'b0);
    check({tag, "_tx_packet"},   tx_packet,   64'h0);
    check({tag, "_rsp_valid"},   rsp_valid,   1'b0);
    check({tag, "_rsp_rdata"},   rsp_rdata,   8'h00);
    check({tag, "_rsp_error"},   rsp_error,   2'b00);
    check({tag, "_data_valid"},  data_valid,  1'b0);
    check({tag, "_data_packet"}, data_packet, 64'h0);
  endtask

  // mode: 0 = no reply (timeout), 1 = good reply, 2 = reply with bit63 flipped.
  // delay: wait cycle (1 = first cycle after the tx handshake) carrying the reply.
  task automatic run_cmd(input logic wr, input logic [7:0] chip, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] rdata, input int bp,
                         input int mode, input int delay, input int noise);
    logic [63:0] exp_tx, pkt;
    logic [7:0]  exp_rd;
    logic [1:0]  exp_err;
    int          exp_k, w, k;
    bit          done;
    exp_tx = make_pkt(wr ? 2'b10 : 2'b11, chip, addr, wr ? wdata : 8'h00, MAGIC);
    w = 0;
    while (!cmd_ready && w < 50) begin tick(); w++; end
    check("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_chip_id = chip; cmd_addr = addr; cmd_wdata = wdata;
    tick();
    check("tx_valid_rise",  tx_valid,   1'b1);
    check("tx_packet",      tx_packet,  exp_tx);
    check("tx_parity",      ^tx_packet, 1'b1);
    check("cmd_ready_busy", cmd_ready,  1'b0);
    // A competing command held during SEND must be ignored.
    cmd_write = ~wr; cmd_chip_id = ~chip; cmd_addr = ~addr; cmd_wdata = ~wdata;
    for (int i = 0; i < bp; i++) begin
      tx_ready = 1'b0;
      tick();
      check("bp_tx_valid",  tx_valid,  1'b1);
      check("bp_tx_packet", tx_packet, exp_tx);
      check("bp_cmd_ready", cmd_ready, 1'b0);
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0; cmd_valid = 1'b0;
    if (wr) begin
      exp_k = 1; exp_rd = 8'h00; exp_err = 2'b00;
    end else if (mode == 0) begin
      exp_k = TO; exp_rd = 8'h00; exp_err = 2'b01;
    end else begin
      exp_k = delay + 1;
      exp_rd  = (mode == 1) ? rdata : 8'h00;
      exp_err = (mode == 1) ? 2'b00 : 2'b10;
    end
    k = 1; done = 0;
    while (!done && k <= TO + 4) begin
      rx_valid = 1'b0;
      check("rsp_valid_timing", rsp_valid, (k == exp_k));
      if (k == exp_k || rsp_valid) begin
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_error", rsp_error, exp_err);
        done = 1;
      end else if (!wr) begin
        if (k <= noise) begin
          pkt = noise_pkt(k - 1, chip, addr, 8'($urandom));
          rx_packet = pkt; rx_valid = 1'b1;
          fwd_q.push_back(pkt);
        end else if (mode != 0 && k == delay) begin
          pkt = make_pkt(2'b11, chip, addr, rdata, MAGIC);
          if (mode == 2) pkt[63] = ~pkt[63];
          rx_packet = pkt; rx_valid = 1'b1;
        end
      end
      if (!done) begin tick(); k++; end
    end
    if (!done) check("rsp_never_seen", rsp_valid, 1'b1);
    rx_valid = 1'b0;
    tick();
    check("rsp_single_pulse", rsp_valid, 1'b0);
    check("cmd_ready_after",  cmd_ready, 1'b1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pkt;
    int r, dly;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_chip_id = 8'h00;
    cmd_addr = 8'h00; cmd_wdata = 8'h00; tx_ready = 1'b0; rx_packet = '0; rx_valid = 1'b0;
    tick(); tick();
    check_reset_values("reset");
    reset_n = 1'b1;
    tick();

    // Directed cases
    run_cmd(1'b1, 8'h12, 8'h05, 8'hA5, 8'h00, 0, 0, 0, 0);   // write
    run_cmd(1'b0, 8'h12, 8'h20, 8'h00, 8'h3C, 0, 1, 3, 0);   // read, direct reply
    run_cmd(1'b0, 8'h12, 8'h20, 8'h00, 8'h5A, 0, 1, 3, 1);   // wrong address first
    run_cmd(1'b0, 8'h12, 8'h20, 8'h00, 8'h77, 0, 2, 2, 0);   // parity error
    run_cmd(1'b0, 8'h12, 8'h20, 8'h00, 8'h00, 0, 0, 0, 0);   // timeout
    run_cmd(1'b0, 8'h34, 8'h09, 8'h00, 8'hC3, 0, 1, 15, 4);  // match on final wait cycle
    run_cmd(1'b1, 8'h40, 8'hFF, 8'h0F, 8'h00, 10, 0, 0, 0);  // backpressure on a write
    run_cmd(1'b0, 8'h41, 8'h02, 8'h00, 8'h99, 10, 1, 5, 2);  // backpressure on a read

    // Reset while waiting for a read reply
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_chip_id = 8'h12; cmd_addr = 8'h20;
    tick();
    cmd_valid = 1'b0; tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    tick(); tick();
    check("wait_no_rsp", rsp_valid, 1'b0);
    reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midreset_no_rsp", rsp_valid, 1'b0);
    end
    reset_n = 1'b1;
    tick();
    run_cmd(1'b0, 8'h12, 8'h20, 8'h00, 8'hE1, 0, 1, 4, 1);

    // Randomized transactions with idle traffic
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        pkt = {$urandom, $urandom};
        rx_packet = pkt; rx_valid = 1'b1;
        fwd_q.push_back(pkt);
        tick();
        rx_valid = 1'b0;
      end
      r   = $urandom_range(0, 5);
      dly = $urandom_range(1, 15);
      run_cmd(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              $urandom_range(0, 4), (r == 0) ? 0 : ((r == 1) ? 2 : 1), dly,
              (r == 0) ? $urandom_range(0, 4) : $urandom_range(0, (dly > 4) ? 3 : dly - 1));
    end

    tick(); tick();
    check("fwd_drain", fwd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
